vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter_if.sv | 36 +++
 rtl/vram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_vram_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// VRAM arbiter bus bundle: video fetch port, CPU-snoop write port and
// the VRAM pin-side strobes. The slave modport is the arbiter's view.
interface vram_arbiter_if;
    logic [2:0]  seq;
    logic        vidActive;
    logic [14:0] vidAddr;
    logic        vidBufSel;
    logic [7:0]  vidData;
    logic        vidValid;
    logic        wrReq;
    logic [14:0] wrAddr;
    logic [7:0]  wrData;
    logic        wrBuf;
    logic        wrFull;
    logic        wrOverflow;
    logic [14:0] vramAddr;
    logic [7:0]  vramDout;
    logic        vramDoe;
    logic [7:0]  vramDin;
    logic        nvramOE;
    logic        nvramWE;
    logic        nvramCE0;
    logic        nvramCE1;

    modport master (
        output seq, vidActive, vidAddr, vidBufSel, wrReq, wrAddr, wrData, wrBuf, vramDin,
        input  vidData, vidValid, wrFull, wrOverflow, vramAddr, vramDout, vramDoe,
        input  nvramOE, nvramWE, nvramCE0, nvramCE1
    );

    modport slave (
        input  seq, vidActive, vidAddr, vidBufSel, wrReq, wrAddr, wrData, wrBuf, vramDin,
        output vidData, vidValid, wrFull, wrOverflow, vramAddr, vramDout, vramDoe,
        output nvramOE, nvramWE, nvramCE0, nvramCE1
    );
endinterface

// File: rtl/vram_arbiter.sv
// VRAM arbiter: splits each 8-clock byte cycle into two 4-clock slots.
// Slot A serves the video fetch when the display is active, otherwise a
// queued CPU write; slot B only ever serves queued writes.
// Build option VRAM_ARB_FIFO_EN: 4-deep write queue; undefined: a single
// holding register.
module vram_arbiter (
    input  logic          pixClk,
    input  logic          reset,
    vram_arbiter_if.slave bus
);
    localparam int unsigned AW = 15;
    localparam int unsigned DW = 8;
`ifdef VRAM_ARB_FIFO_EN
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 2;
    localparam int unsigned CW    = 3;
`else
    localparam int unsigned DEPTH = 1;
    localparam int unsigned PW    = 1;
    localparam int unsigned CW    = 1;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          buf_sel;
    } wr_entry_t;

    state_t        state, state_nx;
    logic [1:0]    phase, phase_nx;

    wr_entry_t     fifo_mem [DEPTH];
    wr_entry_t     head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop, full, ovf_q;

    logic [AW-1:0] addr_q, addr_nx;
    logic [DW-1:0] dout_q, dout_nx;
    logic [DW-1:0] vid_data_q, vid_data_nx;
    logic          doe_q, doe_nx;
    logic          oe_n_q, oe_n_nx;
    logic          we_n_q, we_n_nx;
    logic          ce0_n_q, ce0_n_nx;
    logic          ce1_n_q, ce1_n_nx;
    logic          vid_valid_q, vid_valid_nx;

    assign head = fifo_mem[rd_ptr];
    assign full = (count == CW'(DEPTH));
    assign push = bus.wrReq && !full;

    assign bus.wrFull     = full;
    assign bus.wrOverflow = ovf_q;
    assign bus.vramAddr   = addr_q;
    assign bus.vramDout   = dout_q;
    assign bus.vramDoe    = doe_q;
    assign bus.nvramOE    = oe_n_q;
    assign bus.nvramWE    = we_n_q;
    assign bus.nvramCE0   = ce0_n_q;
    assign bus.nvramCE1   = ce1_n_q;
    assign bus.vidData    = vid_data_q;
    assign bus.vidValid   = vid_valid_q;

    // Next-state and next-output decode; an op runs 4 clocks, then re-decides on a slot boundary.
    always_comb begin
        state_nx     = state;
        phase_nx     = phase + 2'd1;
        addr_nx      = addr_q;
        dout_nx      = dout_q;
        doe_nx       = doe_q;
        oe_n_nx      = oe_n_q;
        we_n_nx      = 1'b1;
        ce0_n_nx     = ce0_n_q;
        ce1_n_nx     = ce1_n_q;
        vid_data_nx  = vid_data_q;
        vid_valid_nx = 1'b0;
        pop          = 1'b0;

        if (state == RD && phase == 2'd3) begin
            vid_data_nx  = bus.vramDin;
            vid_valid_nx = 1'b1;
        end

        if (state == IDLE || phase == 2'd3) begin
            phase_nx = 2'd0;
            state_nx = IDLE;
            addr_nx  = '0;
            dout_nx  = '0;
            doe_nx   = 1'b0;
            oe_n_nx  = 1'b1;
            ce0_n_nx = 1'b1;
            ce1_n_nx = 1'b1;
            if (bus.seq == 3'd0 && bus.vidActive) begin
                state_nx = RD;
                addr_nx  = bus.vidAddr;
                oe_n_nx  = 1'b0;
                ce0_n_nx = bus.vidBufSel;
                ce1_n_nx = !bus.vidBufSel;
            end else if ((bus.seq == 3'd0 || bus.seq == 3'd4) && count != '0) begin
                state_nx = WR;
                pop      = 1'b1;
                addr_nx  = head.addr;
                dout_nx  = head.data;
                doe_nx   = 1'b1;
                ce0_n_nx = head.buf_sel;
                ce1_n_nx = !head.buf_sel;
            end
        end else begin
            // WE low only in the two middle clocks of a write.
            we_n_nx = !(state == WR && phase != 2'd2);
        end
    end

    // State and registered pin outputs.
    always_ff @(posedge pixClk) begin
        if (reset) begin
            state       <= IDLE;
            phase       <= 2'd0;
            addr_q      <= '0;
            dout_q      <= '0;
            doe_q       <= 1'b0;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ce0_n_q     <= 1'b1;
            ce1_n_q     <= 1'b1;
            vid_data_q  <= '0;
            vid_valid_q <= 1'b0;
        end else begin
            state       <= state_nx;
            phase       <= phase_nx;
            addr_q      <= addr_nx;
            dout_q      <= dout_nx;
            doe_q       <= doe_nx;
            oe_n_q      <= oe_n_nx;
            we_n_q      <= we_n_nx;
            ce0_n_q     <= ce0_n_nx;
            ce1_n_q     <= ce1_n_nx;
            vid_data_q  <= vid_data_nx;
            vid_valid_q <= vid_valid_nx;
        end
    end

    // Write-queue pointers, occupancy and sticky overflow flag.
    always_ff @(posedge pixClk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (bus.wrReq && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Write-queue storage; contents are don't-care while the slot is empty.
    always_ff @(posedge pixClk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{addr: bus.wrAddr, data: bus.wrData, buf_sel: bus.wrBuf};
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: video read slot, write slot timing,
// write ordering, queue full/overflow, reset mid-write, random invariants.
module tb_vram_arbiter;
`ifdef VRAM_ARB_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       pixClk = 1'b0;
    logic       reset  = 1'b1;
    logic [2:0] hcnt   = 3'd0;
    int         vectors = 0;
    int         errors  = 0;

    vram_arbiter_if bus ();

    vram_arbiter dut (
        .pixClk (pixClk),
        .reset  (reset),
        .bus    (bus)
    );

    always #20 pixClk = ~pixClk;

    // Free-running horizontal counter feeding seq.
    always @(posedge pixClk) hcnt <= hcnt + 3'd1;
    assign bus.seq = hcnt;

    task automatic step();
        @(negedge pixClk);
    endtask

    task automatic wait_seq(input logic [2:0] v);
        int n;
        n = 0;
        do begin
            @(negedge pixClk);
            n++;
        end while (bus.seq != v && n < 16);
        if (bus.seq != v) begin
            vectors++; errors++;
            $display("FAIL wait_seq: seq=%0d required %0d", bus.seq, v);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.vidActive = 1'b0; bus.vidAddr = '0; bus.vidBufSel = 1'b0;
        bus.wrReq = 1'b0; bus.wrAddr = '0; bus.wrData = '0; bus.wrBuf = 1'b0;
        bus.vramDin = 8'h00;
        do_reset();
        vectors++;
        if ({bus.nvramOE, bus.nvramWE, bus.nvramCE0, bus.nvramCE1, bus.vramDoe,
             bus.wrFull, bus.wrOverflow, bus.vidValid} !== 8'hF0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 11110000",
                     {bus.nvramOE, bus.nvramWE, bus.nvramCE0, bus.nvramCE1, bus.vramDoe,
                      bus.wrFull, bus.wrOverflow, bus.vidValid});
        end
        vectors++;
        if ({bus.vramAddr, bus.vramDout, bus.vidData} !== 31'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%h dout=%h vid=%h required all 0",
                     bus.vramAddr, bus.vramDout, bus.vidData);
        end
    endtask

    task automatic test_read();
        do_reset();
        bus.vidActive = 1'b1; bus.vidAddr = 15'h1234; bus.vidBufSel = 1'b1;
        bus.vramDin = 8'hA5;
        wait_seq(3'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            vectors++;
            if ({bus.nvramOE, bus.nvramWE, bus.nvramCE0, bus.nvramCE1, bus.vramDoe,
                 bus.vidValid} !== 6'b011000 || bus.vramAddr !== 15'h1234) begin
                errors++;
                $display("FAIL read_k%0d: oe/we/ce0/ce1/doe/vld=%b addr=%h required 011000 1234",
                         k, {bus.nvramOE, bus.nvramWE, bus.nvramCE0, bus.nvramCE1,
                             bus.vramDoe, bus.vidValid}, bus.vramAddr);
            end
            // Dropping vidActive mid-read must not cut the read short.
            if (k == 1) bus.vidActive = 1'b0;
        end
        step();
        vectors++;
        if (bus.vidData !== 8'hA5 || bus.vidValid !== 1'b1 || bus.nvramOE !== 1'b1 ||
            bus.vramAddr !== 15'h0) begin
            errors++;
            $display("FAIL read_done: vid=%h vld=%b oe=%b addr=%h required A5 1 1 0000",
                     bus.vidData, bus.vidValid, bus.nvramOE, bus.vramAddr);
        end
        step();
        vectors++;
        if (bus.vidValid !== 1'b0 || bus.vidData !== 8'hA5) begin
            errors++;
            $display("FAIL read_pulse: vld=%b vid=%h required 0 A5", bus.vidValid, bus.vidData);
        end
        wait_seq(3'd1);
        vectors++;
        if (bus.nvramOE !== 1'b1 || bus.nvramCE1 !== 1'b1) begin
            errors++;
            $display("FAIL read_inactive: oe=%b ce1=%b required 1 1", bus.nvramOE, bus.nvramCE1);
        end
    endtask

    task automatic test_write_slot_b();
        logic exp_full;
        exp_full = (DEPTH == 1);
        do_reset();
        bus.vidActive = 1'b1; bus.vidAddr = 15'h0200; bus.vidBufSel = 1'b0;
        wait_seq(3'd1);
        bus.wrReq = 1'b1; bus.wrAddr = 15'h0100; bus.wrData = 8'h3C; bus.wrBuf = 1'b0;
        step();
        bus.wrReq = 1'b0;
        vectors++;
        if (bus.wrFull !== exp_full || bus.nvramWE !== 1'b1) begin
            errors++;
            $display("FAIL wr_queued: full=%b we=%b required %b 1", bus.wrFull, bus.nvramWE, exp_full);
        end
        wait_seq(3'd5);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({bus.nvramOE, bus.nvramCE0, bus.nvramCE1, bus.vramDoe} !== 4'b1011 ||
                bus.nvramWE !== ((k == 1 || k == 2) ? 1'b0 : 1'b1) ||
                bus.vramAddr !== 15'h0100 || bus.vramDout !== 8'h3C) begin
                errors++;
                $display("FAIL write_k%0d: oe/ce0/ce1/doe=%b we=%b addr=%h dout=%h required 1011 %b 0100 3C",
                         k, {bus.nvramOE, bus.nvramCE0, bus.nvramCE1, bus.vramDoe}, bus.nvramWE,
                         bus.vramAddr, bus.vramDout, (k == 1 || k == 2) ? 1'b0 : 1'b1);
            end
            if (k < 3) step();
        end
        wait_seq(3'd1);
        vectors++;
        if (bus.nvramOE !== 1'b0 || bus.vramAddr !== 15'h0200 || bus.wrFull !== 1'b0 ||
            bus.nvramCE0 !== 1'b0) begin
            errors++;
            $display("FAIL write_next_rd: oe=%b addr=%h full=%b ce0=%b required 0 0200 0 0",
                     bus.nvramOE, bus.vramAddr, bus.wrFull, bus.nvramCE0);
        end
    endtask

    task automatic test_two_writes();
        do_reset();
        bus.vidActive = 1'b0;
        wait_seq(3'd5);
        bus.wrReq = 1'b1; bus.wrAddr = 15'h0011; bus.wrData = 8'h11; bus.wrBuf = 1'b1;
        step();
        bus.wrReq = 1'b0;
        wait_seq(3'd1);
        vectors++;
        if (bus.vramAddr !== 15'h0011 || bus.vramDout !== 8'h11 || bus.vramDoe !== 1'b1 ||
            {bus.nvramCE0, bus.nvramCE1} !== 2'b10) begin
            errors++;
            $display("FAIL two_wr_a: addr=%h dout=%h doe=%b ce=%b required 0011 11 1 10",
                     bus.vramAddr, bus.vramDout, bus.vramDoe, {bus.nvramCE0, bus.nvramCE1});
        end
        bus.wrReq = 1'b1; bus.wrAddr = 15'h0022; bus.wrData = 8'h22; bus.wrBuf = 1'b0;
        step();
        bus.wrReq = 1'b0;
        vectors++;
        if (bus.nvramWE !== 1'b0 || bus.nvramOE !== 1'b1) begin
            errors++;
            $display("FAIL two_wr_a_we: we=%b oe=%b required 0 1", bus.nvramWE, bus.nvramOE);
        end
        wait_seq(3'd5);
        vectors++;
        if (bus.vramAddr !== 15'h0022 || bus.vramDout !== 8'h22 ||
            {bus.nvramCE0, bus.nvramCE1} !== 2'b01) begin
            errors++;
            $display("FAIL two_wr_b: addr=%h dout=%h ce=%b required 0022 22 01",
                     bus.vramAddr, bus.vramDout, {bus.nvramCE0, bus.nvramCE1});
        end
        step();
        vectors++;
        if (bus.nvramWE !== 1'b0) begin
            errors++;
            $display("FAIL two_wr_b_we: we=%b required 0", bus.nvramWE);
        end
        wait_seq(3'd1);
        vectors++;
        if (bus.vramDoe !== 1'b0 || {bus.nvramOE, bus.nvramWE, bus.nvramCE0, bus.nvramCE1} !== 4'hF ||
            bus.vramAddr !== 15'h0) begin
            errors++;
            $display("FAIL two_wr_idle: doe=%b strobes=%b addr=%h required 0 1111 0000",
                     bus.vramDoe, {bus.nvramOE, bus.nvramWE, bus.nvramCE0, bus.nvramCE1}, bus.vramAddr);
        end
    endtask

    task automatic test_overflow();
        int   n_seen;
        logic exp_ovf2;
        exp_ovf2 = (DEPTH == 1);
        do_reset();
        bus.vidActive = 1'b1; bus.vidAddr = 15'h0300; bus.vramDin = 8'hA5;
        wait_seq(3'd5);
        for (int i = 0; i < 5; i++) begin
            bus.wrReq = 1'b1; bus.wrAddr = 15'(16'h0400 + i); bus.wrData = 8'(8'h40 + i);
            bus.wrBuf = 1'b0;
            step();
            if (i == 1) begin
                vectors++;
                if (bus.wrOverflow !== exp_ovf2 || bus.wrFull !== 1'b1 && DEPTH == 1) begin
                    errors++;
                    $display("FAIL ovf_after2: ovf=%b full=%b required ovf %b", bus.wrOverflow,
                             bus.wrFull, exp_ovf2);
                end
            end
            if (i == 3) begin
                vectors++;
                if (bus.wrFull !== 1'b1 || bus.wrOverflow !== exp_ovf2) begin
                    errors++;
                    $display("FAIL ovf_after4: full=%b ovf=%b required 1 %b", bus.wrFull,
                             bus.wrOverflow, exp_ovf2);
                end
            end
        end
        bus.wrReq = 1'b0;
        bus.vidActive = 1'b0;
        vectors++;
        if (bus.wrFull !== 1'b1 || bus.wrOverflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after5: full=%b ovf=%b required 1 1", bus.wrFull, bus.wrOverflow);
        end
        n_seen = 0;
        repeat (32) begin
            step();
            if ((bus.seq == 3'd5 || bus.seq == 3'd1) && bus.vramDoe === 1'b1) begin
                vectors++;
                if (n_seen >= DEPTH || bus.vramDout !== 8'(8'h40 + n_seen)) begin
                    errors++;
                    $display("FAIL drain_order[%0d]: dout=%h required %h", n_seen,
                             bus.vramDout, 8'(8'h40 + n_seen));
                end
                n_seen++;
            end
        end
        vectors++;
        if (n_seen != DEPTH || bus.wrOverflow !== 1'b1 || bus.wrFull !== 1'b0) begin
            errors++;
            $display("FAIL drain_count: writes=%0d ovf=%b full=%b required %0d 1 0",
                     n_seen, bus.wrOverflow, bus.wrFull, DEPTH);
        end
    endtask

    task automatic test_reset_mid_write();
        logic saw_doe;
        bus.vidActive = 1'b0;
        wait_seq(3'd5);
        bus.wrReq = 1'b1; bus.wrAddr = 15'h0077; bus.wrData = 8'h77; bus.wrBuf = 1'b1;
        step();
        bus.wrAddr = 15'h0078; bus.wrData = 8'h78;
        step();
        bus.wrReq = 1'b0;
        wait_seq(3'd2);
        vectors++;
        if (bus.nvramWE !== 1'b0 || bus.vramAddr !== 15'h0077) begin
            errors++;
            $display("FAIL rst_wr_k1: we=%b addr=%h required 0 0077", bus.nvramWE, bus.vramAddr);
        end
        reset = 1'b1;
        step();
        vectors++;
        if ({bus.nvramOE, bus.nvramWE, bus.nvramCE0, bus.nvramCE1, bus.vramDoe,
             bus.wrFull, bus.wrOverflow, bus.vidValid} !== 8'hF0 ||
            {bus.vramAddr, bus.vramDout, bus.vidData} !== 31'h0) begin
            errors++;
            $display("FAIL rst_wr_abort: flags=%b addr=%h dout=%h vid=%h required 11110000 0 0 0",
                     {bus.nvramOE, bus.nvramWE, bus.nvramCE0, bus.nvramCE1, bus.vramDoe,
                      bus.wrFull, bus.wrOverflow, bus.vidValid}, bus.vramAddr, bus.vramDout, bus.vidData);
        end
        reset = 1'b0;
        saw_doe = 1'b0;
        repeat (16) begin
            step();
            if (bus.vramDoe !== 1'b0) saw_doe = 1'b1;
        end
        vectors++;
        if (saw_doe !== 1'b0) begin
            errors++;
            $display("FAIL rst_wr_flush: write seen after reset=%b required 0", saw_doe);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.vidActive = ($urandom_range(0, 3) != 0);
            bus.vidAddr   = 15'($urandom);
            bus.vidBufSel = 1'($urandom);
            bus.wrReq     = ($urandom_range(0, 5) == 0);
            bus.wrAddr    = 15'($urandom);
            bus.wrData    = 8'($urandom);
            bus.wrBuf     = 1'($urandom);
            bus.vramDin   = 8'($urandom);
            step();
            vectors++;
            if (bus.nvramOE === 1'b0 && bus.nvramWE === 1'b0) begin
                errors++;
                $display("FAIL rand_oe_we: cycle %0d oe=%b we=%b required not both 0", c,
                         bus.nvramOE, bus.nvramWE);
            end
            vectors++;
            if (bus.nvramCE0 === 1'b0 && bus.nvramCE1 === 1'b0) begin
                errors++;
                $display("FAIL rand_ce: cycle %0d ce0=%b ce1=%b required at most one 0", c,
                         bus.nvramCE0, bus.nvramCE1);
            end
            vectors++;
            if (bus.nvramWE === 1'b0 && bus.vramDoe !== 1'b1) begin
                errors++;
                $display("FAIL rand_we_doe: cycle %0d we=%b doe=%b required doe 1 while we 0", c,
                         bus.nvramWE, bus.vramDoe);
            end
        end
        bus.wrReq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_slot_b();
        test_two_writes();
        test_overflow();
        test_reset_mid_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL timeout: simulation bound reached");
        $fatal(1);
    end
endmodule
